seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
Downstream consumer of the core's 32-bit `data_seg` debug word. It drives the board's 4-digit multiplexed seven-segment display with hexadecimal digits. The block time-multiplexes the anodes, snapshots `data_seg` once per scan frame so a frame never mixes two values, and selects which 16-bit half is shown: low, high, or auto-alternating. It is instantiated in the top level next to the core, on the same clock.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range ≥2.
- PAGE_FRAMES, 500: frames per page in auto mode; legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (rst==0 resets at the next posedge).
- data_seg  input  32  value to display, driven by the core.
- page_mode  input  2  00 = low half, 01 = high half, 10 = auto-alternate, 11 = low half.
- blank_lz  input  1  1 = blank leading zero digits.
- anode  output  4  digit enables, active-low; anode[0] is the rightmost digit.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, active-low; lit on digit 0 only while the high page is shown.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst==0 at posedge, including mid-frame):
  - div_cnt=0, digit_idx=0, snapshot=0, page=0, frame_cnt=0.
  - anode=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - slot_tick is asserted when div_cnt==REFRESH_DIV-1.
- Digit index:
  - On slot_tick, digit_idx increments modulo 4 (3→0).
  - Frame = 4*REFRESH_DIV cycles.
- Frame boundary (slot_tick with digit_idx==3), all at the same edge:
  - snapshot<=data_seg.
  - page is updated.
  - frame_tick<=1 for exactly one cycle.
  - data_seg changes between boundaries are not visible until the next boundary.
- Page update at a frame boundary:
  - Mode 00/11: page<=0.
  - Mode 01: page<=1.
  - Mode 10:
    - frame_cnt increments.
    - When frame_cnt==PAGE_FRAMES-1: frame_cnt<=0 and page toggles.
  - frame_cnt is held at 0 whenever page_mode!=10.
  - A page_mode change mid-frame takes effect only at the next boundary.
- Nibble select:
  - half = page ? snapshot[31:16] : snapshot[15:0].
  - Digit i shows half[4i+3:4i].
- Leading-zero blanking (blank_lz==1):
  - Digit i (i=3..1) is blank iff its nibble and all higher nibbles are 0.
  - Digit 0 is never blank, so value 0 shows "0".
  - Blanked slot: anode=4'b1111, seg=7'b1111111.
- Outputs:
  - Registered, computed from the current digit_idx/snapshot/page.
  - One cycle of latency after digit_idx changes.
  - Active slot: anode = ~(4'b0001<<digit_idx).
- Hex decode (seg[6:0], active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp:
  - dp=0 only when page==1 and the active slot is digit 0.
  - dp=1 otherwise, including blanked slots.
- Only one anode is low at any cycle, never more.

Test Plan (REFRESH_DIV=4, PAGE_FRAMES=2):
- Reset / first slots:
  - Stimulus: hold rst=0 for 3 cycles, then release; data_seg=32'h0000_1234, page_mode=00, blank_lz=0.
  - During reset: anode=1111, seg=1111111.
  - After release: snapshot is 0 for the first frame, so anode walks 1110→1101→1011→0111 every 4 cycles with seg=1000000 ("0").
  - frame_tick fires at cycle 16; the following frame shows 4,3,2,1 on digits 0..3.
- Snapshot isolation:
  - Stimulus: change data_seg from 32'h0000_1234 to 32'h0000_ABCD mid-frame.
  - Current frame still shows 1234; the next frame shows digit0 seg=0100001 (d), digit3 seg=0001000 (A).
- Page modes:
  - Stimulus: data_seg=32'hF00D_0000, page_mode=01.
  - From the next boundary, digits show D,0,0,F; dp=0 only in the digit-0 slot.
  - Stimulus: page_mode=10.
  - page toggles every 2 frames (32 cycles); dp follows page.
- Leading-zero blanking:
  - Stimulus: blank_lz=1, data_seg=32'h0000_0050.
  - Digits 3 and 2 are blank (anode=1111 in their slots); digit1 seg=0010010, digit0 seg=1000000.
  - Stimulus: data_seg=0.
  - Only digit 0 lights, showing "0".
- Reset mid-operation:
  - Stimulus: assert rst=0 during digit_idx=2 for one cycle.
  - Next cycle: reset values on all outputs; the scan restarts from digit 0, showing 0 until the next boundary.
- Decode sweep:
  - Stimulus: data_seg=32'h0123_4567, then 32'h89AB_CDEF, in both pages.
  - All 16 seg codes match the decode table exactly.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display driver for the core's 32-bit debug word.
// Snapshots data_seg once per scan frame and shows the low, high or alternating 16-bit half.
module seg7_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned PAGE_FRAMES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_seg,
  input  logic [1:0]  page_mode,
  input  logic        blank_lz,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FRM_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

  typedef enum logic {
    PAGE_LO = 1'b0,
    PAGE_HI = 1'b1
  } page_t;

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_digit_idx;
  logic [31:0]      r_snapshot;
  page_t            r_page;
  logic [FRM_W-1:0] r_frame_cnt;
  logic [3:0]       r_anode;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_tick;

  logic        w_slot_tick;
  logic        w_boundary;
  logic [15:0] w_half;
  logic [15:0] w_upper;
  logic        w_blank;
  logic [6:0]  w_seg_dec;

  always_comb begin
    w_slot_tick = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    w_boundary  = w_slot_tick && (r_digit_idx == 2'd3);
    w_half      = (r_page == PAGE_HI) ? r_snapshot[31:16] : r_snapshot[15:0];
    // Active nibble plus everything above it; all-zero means this digit is a leading zero.
    w_upper     = w_half >> {r_digit_idx, 2'b00};
    w_blank     = blank_lz && (r_digit_idx != 2'd0) && (w_upper == '0);
  end

  always_comb begin
    w_seg_dec = '1;
    case (w_upper[3:0])
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      4'hF: w_seg_dec = 7'b0001110;
      default: w_seg_dec = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt    <= '0;
      r_digit_idx  <= '0;
      r_snapshot   <= '0;
      r_page       <= PAGE_LO;
      r_frame_cnt  <= '0;
      r_anode      <= '1;
      r_seg        <= '1;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;

      if (w_slot_tick) begin
        r_div_cnt   <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      if (page_mode != 2'b10) begin
        r_frame_cnt <= '0;
      end

      if (w_boundary) begin
        r_snapshot   <= data_seg;
        r_frame_tick <= 1'b1;
        case (page_mode)
          2'b01: r_page <= PAGE_HI;
          2'b10: begin
            if (r_frame_cnt == FRM_W'(PAGE_FRAMES - 1)) begin
              r_frame_cnt <= '0;
              r_page      <= (r_page == PAGE_HI) ? PAGE_LO : PAGE_HI;
            end else begin
              r_frame_cnt <= r_frame_cnt + FRM_W'(1);
            end
          end
          default: r_page <= PAGE_LO;
        endcase
      end

      // Outputs reflect the pre-edge slot state, giving one cycle of display latency.
      r_anode <= w_blank ? 4'b1111 : ~(4'b0001 << r_digit_idx);
      r_seg   <= w_blank ? 7'b1111111 : w_seg_dec;
      r_dp    <= !((r_page == PAGE_HI) && (r_digit_idx == 2'd0));
    end
  end

  assign anode      = r_anode;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a cycle-count based reference model queues
// the expected outputs for each edge and an independent monitor checks them.
module tb_seg7_scan_display;

  localparam int unsigned RD = 4;
  localparam int unsigned PF = 2;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk;
  logic        rst;
  logic [31:0] data_seg;
  logic [1:0]  page_mode;
  logic        blank_lz;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_tests;
  int n_fail;
  exp_t exp_q[$];

  // Reference model state: cycles since reset release, frame snapshot, page, frames on page.
  int unsigned m_t;
  logic [31:0] m_snap;
  bit          m_page;
  int unsigned m_fcnt;

  seg7_scan_display #(
    .REFRESH_DIV(RD),
    .PAGE_FRAMES(PF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_seg  (data_seg),
    .page_mode (page_mode),
    .blank_lz  (blank_lz),
    .anode     (anode),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_step(input logic r, input logic [31:0] d,
                                      input logic [1:0] mode, input logic b);
    exp_t        e;
    int unsigned digit;
    logic [15:0] half;
    logic [15:0] upper;
    bit          blank;
    if (!r) begin
      m_t = 0; m_snap = '0; m_page = 1'b0; m_fcnt = 0;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
    end else begin
      digit = (m_t / RD) % 4;
      half  = m_page ? m_snap[31:16] : m_snap[15:0];
      upper = half >> (4 * digit);
      blank = b && (digit != 0) && (upper == 16'h0);
      e.an   = blank ? 4'hF : ~(4'(1) << digit);
      e.seg  = blank ? 7'h7F : SEG_TBL[upper[3:0]];
      e.dp   = !(m_page && digit == 0);
      e.tick = 1'b0;
      if (mode != 2'b10) m_fcnt = 0;
      if (m_t % (4 * RD) == 4 * RD - 1) begin
        m_snap = d;
        e.tick = 1'b1;
        case (mode)
          2'b01: m_page = 1'b1;
          2'b10: begin
            m_fcnt++;
            if (m_fcnt == PF) begin
              m_fcnt = 0;
              m_page = !m_page;
            end
          end
          default: m_page = 1'b0;
        endcase
      end
      m_t++;
    end
    return e;
  endfunction

  task automatic cycle(input logic r, input logic [31:0] d, input logic [1:0] mode,
                       input logic b);
    rst = r; data_seg = d; page_mode = mode; blank_lz = b;
    exp_q.push_back(model_step(r, d, mode, b));
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n, input logic [31:0] d, input logic [1:0] mode, input logic b);
    for (int i = 0; i < n; i++) cycle(1'b1, d, mode, b);
  endtask

  // Monitor: checks the DUT's outputs after every edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (anode !== e.an) begin
          n_fail++;
          $display("FAIL anode t=%0t got %b want %b", $time, anode, e.an);
        end
        n_tests++;
        if (seg !== e.seg) begin
          n_fail++;
          $display("FAIL seg t=%0t got %b want %b", $time, seg, e.seg);
        end
        n_tests++;
        if (dp !== e.dp) begin
          n_fail++;
          $display("FAIL dp t=%0t got %b want %b", $time, dp, e.dp);
        end
        n_tests++;
        if (frame_tick !== e.tick) begin
          n_fail++;
          $display("FAIL frame_tick t=%0t got %b want %b", $time, frame_tick, e.tick);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  mode;
    logic        b;
    int          guard;
    n_tests = 0;
    n_fail  = 0;

    // Reset then first frames showing 0 followed by 1234.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0000_1234, 2'b00, 1'b0);
    run(40, 32'h0000_1234, 2'b00, 1'b0);
    // Snapshot isolation: change mid-frame.
    run(6, 32'h0000_1234, 2'b00, 1'b0);
    run(40, 32'h0000_ABCD, 2'b00, 1'b0);
    // Page modes.
    run(40, 32'hF00D_0000, 2'b01, 1'b0);
    run(160, 32'hF00D_0000, 2'b10, 1'b0);
    // Leading-zero blanking.
    run(40, 32'h0000_0050, 2'b00, 1'b1);
    run(40, 32'h0000_0000, 2'b00, 1'b1);
    // Reset pulse while digit 2 is active.
    run(20, 32'h0000_4321, 2'b01, 1'b0);
    guard = 0;
    while (((m_t / RD) % 4) != 2 && guard < 32) begin
      cycle(1'b1, 32'h0000_4321, 2'b01, 1'b0);
      guard++;
    end
    cycle(1'b0, 32'h0000_4321, 2'b01, 1'b0);
    run(40, 32'h0000_4321, 2'b01, 1'b0);
    // Decode sweep, both pages.
    run(40, 32'h0123_4567, 2'b00, 1'b0);
    run(40, 32'h0123_4567, 2'b01, 1'b0);
    run(40, 32'h89AB_CDEF, 2'b00, 1'b0);
    run(40, 32'h89AB_CDEF, 2'b01, 1'b0);
    run(40, 32'h89AB_CDEF, 2'b11, 1'b0);

    // Randomized traffic.
    d = 32'h0; mode = 2'b10; b = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0: d = $urandom;
          1: d = $urandom & 32'h0000_00FF;
          default: d = $urandom & 32'h0F00_0F0F;
        endcase
      end
      if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(59) == 0) b = ~b;
      cycle(($urandom_range(299) == 0) ? 1'b0 : 1'b1, d, mode, b);
    end

    @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
